// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared types and encodings for the multicycle MIPS control path.
//   state_t     - control FSM states
//   OP_*        - IR[31:26] opcodes
//   FUNCT_*     - IR[5:0] R-type function codes
//   ALU_*       - ALU operation encodings driven on alu_ctrl
//   SRCB_*      - ALU B-operand mux encodings
//   PCSRC_*     - next-PC mux encodings
// Optional feature macro used by the top: MULTICYCLE_CTRL_BNE_EN.
package multicycle_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'd32;
   localparam logic [5:0] FUNCT_SUB = 6'd34;
   localparam logic [5:0] FUNCT_AND = 6'd36;
   localparam logic [5:0] FUNCT_OR  = 6'd37;
   localparam logic [5:0] FUNCT_SLT = 6'd42;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // True for opcodes that compute an address in MEMADR.
   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: R-type funct decoder.
//   funct       in  6  IR[5:0]
//   alu_ctrl    out 3  ALU operation for the funct (add when not legal)
//   funct_legal out 1  funct is one of add/sub/and/or/slt
module mc_aludec
   import multicycle_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       funct_legal
);

   always_comb begin
      alu_ctrl    = ALU_ADD;
      funct_legal = 1'b1;
      case (funct)
         FUNCT_ADD: alu_ctrl = ALU_ADD;
         FUNCT_SUB: alu_ctrl = ALU_SUB;
         FUNCT_AND: alu_ctrl = ALU_AND;
         FUNCT_OR:  alu_ctrl = ALU_OR;
         FUNCT_SLT: alu_ctrl = ALU_SLT;
         default:   funct_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle MIPS datapath.
// Sequences lw, sw, R-type, addi, beq, j (and bne when MULTICYCLE_CTRL_BNE_EN is defined)
// and waits on mem_ready for every memory access.
//   clk, reset                 clock (rising edge), async active-low reset
//   opcode, funct, zero        instruction fields and ALU zero flag
//   mem_ready                  memory access completes this cycle
//   iord, mem_write, ir_write  memory address select / write enable / IR load
//   reg_dst, mem_to_reg        register write destination / write-back source
//   reg_write                  register file write enable
//   alu_src_a, alu_src_b       ALU operand selects
//   alu_ctrl                   ALU operation
//   pc_src, pc_en              next-PC select and PC enable
//   illegal_op                 one-cycle pulse in DECODE for unsupported opcode/funct
// Parameter USE_MEM_READY: 0 makes every memory access complete in one cycle.
// Macro MULTICYCLE_CTRL_BNE_EN: enables bne through the BRANCH state.
module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       illegal_op
);

   state_t     state_q, state_d;
   logic [2:0] dec_alu_ctrl;
   logic       funct_legal;
   logic       mem_rdy;
   logic       branch_taken;

   mc_aludec u_aludec (
      .funct       (funct),
      .alu_ctrl    (dec_alu_ctrl),
      .funct_legal (funct_legal)
   );

   assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

`ifdef MULTICYCLE_CTRL_BNE_EN
   assign branch_taken = (opcode == OP_BNE) ? ~zero : zero;
`else
   assign branch_taken = zero;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_ctrl   = ALU_AND;
      pc_src     = PCSRC_ALU;
      pc_en      = 1'b0;
      illegal_op = 1'b0;

      case (state_q)
         FETCH: begin
            // PC + 4 computed alongside the instruction read; both commit on mem_rdy.
            alu_src_b = SRCB_FOUR;
            alu_ctrl  = ALU_ADD;
            ir_write  = mem_rdy;
            pc_en     = mem_rdy;
            if (mem_rdy) state_d = DECODE;
         end
         DECODE: begin
            // Branch target precomputed into ALUOut.
            alu_src_b = SRCB_IMMSH;
            alu_ctrl  = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE: begin
                  if (funct_legal) begin
                     state_d = EXECUTE;
                  end else begin
                     state_d    = FETCH;
                     illegal_op = 1'b1;
                  end
               end
               OP_BEQ:  state_d = BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
               OP_BNE:  state_d = BRANCH;
`endif
               OP_ADDI: state_d = ADDIEX;
               OP_J:    state_d = JUMP;
               default: begin
                  state_d    = FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_ctrl  = ALU_ADD;
            if (!is_mem_op(opcode)) state_d = FETCH;
            else if (opcode == OP_LW) state_d = MEMRD;
            else                      state_d = MEMWR;
         end
         MEMRD: begin
            iord = 1'b1;
            if (mem_rdy) state_d = MEMWB;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_d    = FETCH;
         end
         MEMWR: begin
            // Held for the whole wait so the memory sees a stable request.
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_rdy) state_d = FETCH;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_ctrl  = dec_alu_ctrl;
            state_d   = ALUWB;
         end
         ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_ctrl  = ALU_SUB;
            pc_src    = PCSRC_ALUOUT;
            pc_en     = branch_taken;
            state_d   = FETCH;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_ctrl  = ALU_ADD;
            state_d   = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end
         JUMP: begin
            pc_src  = PCSRC_JUMP;
            pc_en   = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase

      // Reset blocks every side effect immediately, even mid-cycle.
      if (!reset) begin
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         pc_en      = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl.
// Each step drives inputs, pushes the expected output vector, and compares it against the
// DUT at the falling edge. Honours MULTICYCLE_CTRL_BNE_EN for the bne step.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_ctrl;
   logic [1:0] pc_src;
   logic       pc_en, illegal_op;
   logic [15:0] obs;

   int tests = 0;
   int fails = 0;
   logic [15:0] sb[$];

   multicycle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .iord       (iord),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_ctrl   (alu_ctrl),
      .pc_src     (pc_src),
      .pc_en      (pc_en),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   assign obs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, alu_ctrl, pc_src, pc_en, illegal_op};

   function automatic logic [15:0] pk(input logic io, mw, irw, rd, m2r, rw, sa,
                                      input logic [1:0] sbv, input logic [2:0] ac,
                                      input logic [1:0] ps, input logic pe, ill);
      return {io, mw, irw, rd, m2r, rw, sa, sbv, ac, ps, pe, ill};
   endfunction

   // Expected output vectors, written out from the state table.
   logic [15:0] e_fetch_r, e_fetch_w, e_decode, e_decode_ill, e_memadr, e_memrd, e_memwb,
                e_memwr, e_exec_slt, e_exec_sub, e_aluwb, e_br_t, e_br_n, e_addiex,
                e_addiwb, e_jump;

   task automatic chk(input string tag, input logic [15:0] e);
      logic [15:0] want;
      sb.push_back(e);
      want = sb.pop_front();
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input logic [15:0] e);
      opcode    = op;
      funct     = fn;
      zero      = z;
      mem_ready = rdy;
      @(negedge clk);
      chk(tag, e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      e_fetch_r    = pk(0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0);
      e_fetch_w    = pk(0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0);
      e_decode     = pk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0);
      e_decode_ill = pk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 1);
      e_memadr     = pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0);
      e_memrd      = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      e_memwb      = pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      e_memwr      = pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      e_exec_slt   = pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 2'b00, 0, 0);
      e_exec_sub   = pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b00, 0, 0);
      e_aluwb      = pk(0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      e_br_t       = pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 1, 0);
      e_br_n       = pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 0);
      e_addiex     = pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0);
      e_addiwb     = pk(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      e_jump       = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1, 0);

      // Reset held 3 cycles with mem_ready=1: enables must stay low.
      reset = 1'b0;
      for (int i = 0; i < 3; i++) cyc("reset_hold", 6'b100011, 6'd0, 0, 1, e_fetch_w);
      reset = 1'b1;

      // lw, zero wait: 5 cycles.
      cyc("lw_fetch",  6'b100011, 6'd0, 0, 1, e_fetch_r);
      cyc("lw_decode", 6'b100011, 6'd0, 0, 1, e_decode);
      cyc("lw_memadr", 6'b100011, 6'd0, 0, 1, e_memadr);
      cyc("lw_memrd",  6'b100011, 6'd0, 0, 1, e_memrd);
      cyc("lw_memwb",  6'b100011, 6'd0, 0, 1, e_memwb);

      // sw with 2 wait cycles in MEMWR: 6 cycles.
      cyc("sw_fetch",  6'b101011, 6'd0, 0, 1, e_fetch_r);
      cyc("sw_decode", 6'b101011, 6'd0, 0, 1, e_decode);
      cyc("sw_memadr", 6'b101011, 6'd0, 0, 1, e_memadr);
      cyc("sw_wait0",  6'b101011, 6'd0, 0, 0, e_memwr);
      cyc("sw_wait1",  6'b101011, 6'd0, 0, 0, e_memwr);
      cyc("sw_done",   6'b101011, 6'd0, 0, 1, e_memwr);

      // Fetch wait then slt.
      cyc("slt_fwait", 6'b000000, 6'd42, 0, 0, e_fetch_w);
      cyc("slt_fetch", 6'b000000, 6'd42, 0, 1, e_fetch_r);
      cyc("slt_dec",   6'b000000, 6'd42, 0, 1, e_decode);
      cyc("slt_exec",  6'b000000, 6'd42, 0, 1, e_exec_slt);
      cyc("slt_wb",    6'b000000, 6'd42, 0, 1, e_aluwb);

      // sub.
      cyc("sub_fetch", 6'b000000, 6'd34, 0, 1, e_fetch_r);
      cyc("sub_dec",   6'b000000, 6'd34, 0, 1, e_decode);
      cyc("sub_exec",  6'b000000, 6'd34, 0, 1, e_exec_sub);
      cyc("sub_wb",    6'b000000, 6'd34, 0, 1, e_aluwb);

      // Illegal funct 39.
      cyc("ill_fetch", 6'b000000, 6'd39, 0, 1, e_fetch_r);
      cyc("ill_dec",   6'b000000, 6'd39, 0, 1, e_decode_ill);

      // addi (also proves the illegal op returned to FETCH).
      cyc("addi_fetch", 6'b001000, 6'd0, 0, 1, e_fetch_r);
      cyc("addi_dec",   6'b001000, 6'd0, 0, 1, e_decode);
      cyc("addi_ex",    6'b001000, 6'd0, 0, 1, e_addiex);
      cyc("addi_wb",    6'b001000, 6'd0, 0, 1, e_addiwb);

      // beq taken / not taken.
      cyc("beqt_fetch", 6'b000100, 6'd0, 1, 1, e_fetch_r);
      cyc("beqt_dec",   6'b000100, 6'd0, 1, 1, e_decode);
      cyc("beqt_br",    6'b000100, 6'd0, 1, 1, e_br_t);
      cyc("beqn_fetch", 6'b000100, 6'd0, 0, 1, e_fetch_r);
      cyc("beqn_dec",   6'b000100, 6'd0, 0, 1, e_decode);
      cyc("beqn_br",    6'b000100, 6'd0, 0, 1, e_br_n);

      // j.
      cyc("j_fetch", 6'b000010, 6'd0, 0, 1, e_fetch_r);
      cyc("j_dec",   6'b000010, 6'd0, 0, 1, e_decode);
      cyc("j_jump",  6'b000010, 6'd0, 0, 1, e_jump);

      // bne with zero=0.
      cyc("bne_fetch", 6'b000101, 6'd0, 0, 1, e_fetch_r);
`ifdef MULTICYCLE_CTRL_BNE_EN
      cyc("bne_dec",   6'b000101, 6'd0, 0, 1, e_decode);
      cyc("bne_br",    6'b000101, 6'd0, 0, 1, e_br_t);
`else
      cyc("bne_dec",   6'b000101, 6'd0, 0, 1, e_decode_ill);
`endif

      // MEMRD wait.
      cyc("lww_fetch", 6'b100011, 6'd0, 0, 1, e_fetch_r);
      cyc("lww_dec",   6'b100011, 6'd0, 0, 1, e_decode);
      cyc("lww_adr",   6'b100011, 6'd0, 0, 1, e_memadr);
      cyc("lww_wait",  6'b100011, 6'd0, 0, 0, e_memrd);
      cyc("lww_rd",    6'b100011, 6'd0, 0, 1, e_memrd);
      cyc("lww_wb",    6'b100011, 6'd0, 0, 1, e_memwb);

      // Async reset in the middle of a MEMWR wait.
      cyc("swr_fetch", 6'b101011, 6'd0, 0, 1, e_fetch_r);
      cyc("swr_dec",   6'b101011, 6'd0, 0, 1, e_decode);
      cyc("swr_adr",   6'b101011, 6'd0, 0, 1, e_memadr);
      cyc("swr_wait",  6'b101011, 6'd0, 0, 0, e_memwr);
      #2;
      chk("swr_pre_reset", e_memwr);
      reset = 1'b0;
      #1;
      chk("swr_async_reset", e_fetch_w);
      @(posedge clk);
      #1;
      cyc("swr_reset_hold", 6'b101011, 6'd0, 0, 1, e_fetch_w);
      reset = 1'b1;
      cyc("swr_after", 6'b100011, 6'd0, 0, 1, e_fetch_r);

      tests++;
      assert (sb.size() === 0) else begin
         fails++;
         $error("FAIL scoreboard_empty: observed %0d expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
